pipe_mux_n: RTL and testbench

PIPE_MUX_N -- requirements
Module: pipe_mux_n

---
 rtl/pipe_mux_n.sv | 105 ++++++++++
 tb/tb_pipe_mux_n.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_n.sv
// Pipelined N:1 lane selector: 2:1 mux tree registered every REG_EVERY levels.
// Define PIPE_MUX_STALL_EN to add out_ready backpressure (elastic pipeline).
module pipe_mux_n #(
  parameter int WIDTH     = 64,
  parameter int SEL_BITS  = 5,
  parameter int REG_EVERY = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [(2**SEL_BITS)*WIDTH-1:0]   in_data,
  input  logic [SEL_BITS-1:0]              in_sel,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  output logic [SEL_BITS-1:0]              out_sel
`ifdef PIPE_MUX_STALL_EN
  ,
  input  logic                             out_ready
`endif
);

  localparam int STAGES = (SEL_BITS + REG_EVERY - 1) / REG_EVERY;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_ready;

`ifdef PIPE_MUX_STALL_EN
  // A stage may load when it is empty or its content moves on this edge.
  for (genvar s = 0; s < STAGES; s++) begin : g_ready
    if (s == STAGES - 1) begin : g_last
      assign stage_ready[s] = !stage_valid[s] || out_ready;
    end else begin : g_mid
      assign stage_ready[s] = !stage_valid[s] || stage_ready[s+1];
    end
  end
`else
  assign stage_ready = '1;
`endif

  assign in_ready = stage_ready[0] && !reset;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO   = s * REG_EVERY;
    localparam int HI   = ((s + 1) * REG_EVERY > SEL_BITS) ? SEL_BITS : (s + 1) * REG_EVERY;
    localparam int NIN  = 2 ** (SEL_BITS - LO);
    localparam int NOUT = 2 ** (SEL_BITS - HI);

    logic [NIN*WIDTH-1:0]  d_in;
    logic [SEL_BITS-1:0]   s_in;
    logic                  v_in;
    logic [NIN*WIDTH-1:0]  lvl;
    logic [NOUT*WIDTH-1:0] q_data;
    logic [SEL_BITS-1:0]   q_sel;
    logic                  q_valid;

    if (s == 0) begin : g_first
      assign d_in = in_data;
      assign s_in = in_sel;
      assign v_in = in_valid;
    end else begin : g_next
      assign d_in = g_stage[s-1].q_data;
      assign s_in = g_stage[s-1].q_sel;
      assign v_in = stage_valid[s-1];
    end

    // Each level halves the lane count in place, resolving one select bit LSB first.
    always_comb begin
      lvl = d_in;
      for (int j = 0; j < HI - LO; j++) begin
        for (int i = 0; i < (NIN >> (j + 1)); i++) begin
          lvl[i*WIDTH +: WIDTH] = s_in[LO+j] ? lvl[(2*i+1)*WIDTH +: WIDTH]
                                             : lvl[(2*i)*WIDTH +: WIDTH];
        end
      end
    end

    // The full select travels with the data so the last stage can report out_sel.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q_valid <= 1'b0;
        q_data  <= '0;
        q_sel   <= '0;
      end else begin
        if (flush) begin
          q_valid <= 1'b0;
        end else if (stage_ready[s]) begin
          q_valid <= v_in;
        end
        if (stage_ready[s]) begin
          q_data <= lvl[NOUT*WIDTH-1:0];
          q_sel  <= s_in;
        end
      end
    end

    assign stage_valid[s] = q_valid;
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = g_stage[STAGES-1].q_data;
  assign out_sel   = g_stage[STAGES-1].q_sel;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Self-checking bench for pipe_mux_n: random traffic against a queue-based
// transaction model, plus directed WIDTH=1 and REG_EVERY=1/5 instances.
module tb_pipe_mux_n;
  localparam int W  = 64;
  localparam int N  = 32;
  localparam int L  = 3;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic [4:0]  sel;
  } item_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [4:0] in_sel;
  logic [N*W-1:0] d_main;
  logic [31:0]    d_w1;
  logic [N*8-1:0] d_r;

  logic rdy_m, ov_m; logic [63:0] od_m; logic [4:0] os_m;
  logic rdy_w, ov_w; logic [0:0]  od_w; logic [4:0] os_w;
  logic rdy_1, ov_1; logic [7:0]  od_1; logic [4:0] os_1;
  logic rdy_5, ov_5; logic [7:0]  od_5; logic [4:0] os_5;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int delivered = 0;
  logic last_acc;
  logic last_rdy;
  item_t q[$];

  always #5 clk = ~clk;

  pipe_mux_n dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(d_main), .in_sel(in_sel), .out_valid(ov_m), .out_data(od_m), .out_sel(os_m)
`ifdef PIPE_MUX_STALL_EN
    , .out_ready(out_ready)
`endif
  );

  pipe_mux_n #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w),
    .in_data(d_w1), .in_sel(in_sel), .out_valid(ov_w), .out_data(od_w), .out_sel(os_w)
`ifdef PIPE_MUX_STALL_EN
    , .out_ready(out_ready)
`endif
  );

  pipe_mux_n #(.WIDTH(8), .REG_EVERY(1)) dut_r1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_1),
    .in_data(d_r), .in_sel(in_sel), .out_valid(ov_1), .out_data(od_1), .out_sel(os_1)
`ifdef PIPE_MUX_STALL_EN
    , .out_ready(out_ready)
`endif
  );

  pipe_mux_n #(.WIDTH(8), .REG_EVERY(5)) dut_r5 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_5),
    .in_data(d_r), .in_sel(in_sel), .out_valid(ov_5), .out_data(od_5), .out_sel(os_5)
`ifdef PIPE_MUX_STALL_EN
    , .out_ready(out_ready)
`endif
  );

  // One cycle: drive at negedge, compare the main DUT with the model, then
  // advance the model by the rules an ideal elastic L-deep pipe obeys.
  task automatic step(input logic v, input logic [4:0] s, input logic ordy, input logic fl);
    logic ordy_eff, exp_rdy, vis, acc;
    item_t it;
    in_valid = v; in_sel = s; out_ready = ordy; flush = fl;
`ifdef PIPE_MUX_STALL_EN
    ordy_eff = ordy;
`else
    ordy_eff = 1'b1;
`endif
    #1;
    vis = (q.size() > 0) && (q[0].due <= cyc);
    exp_rdy = (q.size() < L) || ordy_eff;
    last_rdy = exp_rdy;
    checks++;
    if (rdy_m !== exp_rdy) begin
      errors++; $display("[TB] FAIL in_ready cyc=%0d got=%b exp=%b", cyc, rdy_m, exp_rdy);
    end
    checks++;
    if (ov_m !== vis) begin
      errors++; $display("[TB] FAIL out_valid cyc=%0d got=%b exp=%b", cyc, ov_m, vis);
    end
    if (vis) begin
      checks++;
      if (od_m !== q[0].data) begin
        errors++; $display("[TB] FAIL out_data cyc=%0d got=%h exp=%h", cyc, od_m, q[0].data);
      end
      checks++;
      if (os_m !== q[0].sel) begin
        errors++; $display("[TB] FAIL out_sel cyc=%0d got=%0d exp=%0d", cyc, os_m, q[0].sel);
      end
    end
    acc = v && exp_rdy && !fl;
    last_acc = acc;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (vis && ordy_eff) begin
        void'(q.pop_front());
        delivered++;
        if (q.size() > 0 && q[0].due < cyc + 1) q[0].due = cyc + 1;
      end
      if (acc) begin
        it.due = cyc + L;
        it.data = d_main[int'(s)*W +: W];
        it.sel = s;
        q.push_back(it);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
  endtask

  task automatic rand_main();
    for (int i = 0; i < N*W/32; i++) d_main[i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sel = '0;
    d_main = '0; d_w1 = '0; d_r = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ov_m !== 1'b0 || od_m !== '0 || os_m !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got v=%b d=%h s=%0d exp 0", ov_m, od_m, os_m);
    end
    checks++;
    if (rdy_m !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", rdy_m);
    end
    checks++;
    if ({ov_w, rdy_w, od_w, os_w, ov_1, rdy_1, od_1, os_1, ov_5, rdy_5, od_5, os_5} !== '0) begin
      errors++; $display("[TB] FAIL reset_variants got nonzero exp all 0");
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rdy_m !== 1'b1 || rdy_w !== 1'b1 || rdy_1 !== 1'b1 || rdy_5 !== 1'b1) begin
      errors++; $display("[TB] FAIL release_in_ready got=%b%b%b%b exp=1111", rdy_m, rdy_w, rdy_1, rdy_5);
    end
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_single();
    int c0;
    for (int k = 0; k < N; k++) d_main[k*W +: W] = 64'h0101010101010101 * 64'(k);
    c0 = cyc;
    step(1'b1, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (cyc == c0 + 3) begin
        checks++;
        if (ov_m !== 1'b1 || od_m !== 64'h0202020202020202 || os_m !== 5'd2) begin
          errors++; $display("[TB] FAIL single_lane2 got v=%b d=%h s=%0d exp v=1 d=0202020202020202 s=2", ov_m, od_m, os_m);
        end
      end
      idle(1);
    end
  endtask

  task automatic test_width1();
    logic [4:0] st [5];
    logic       eb [5];
    int r;
    st = '{5'd2, 5'd0, 5'd30, 5'd6, 5'd15};
    eb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    d_w1 = 32'b1100100;
    idle(6);
    for (int t = 0; t < 9; t++) begin
      step(t < 5, (t < 5) ? st[t] : 5'd0, 1'b1, 1'b0);
      r = t + 1;
      checks++;
      if (ov_w !== (r >= 3 && r <= 7)) begin
        errors++; $display("[TB] FAIL w1_valid r=%0d got=%b exp=%b", r, ov_w, (r >= 3 && r <= 7));
      end
      if (r >= 3 && r <= 7) begin
        checks++;
        if (od_w[0] !== eb[r-3] || os_w !== st[r-3]) begin
          errors++; $display("[TB] FAIL w1_data r=%0d got=%b/%0d exp=%b/%0d", r, od_w, os_w, eb[r-3], st[r-3]);
        end
      end
    end
  endtask

  task automatic test_reg_every();
    idle(6);
    for (int k = 0; k < N; k++) d_r[k*8 +: 8] = 8'($urandom) & 8'h7F;
    d_r[31*8 +: 8] = 8'hFF;
    step(1'b1, 5'd31, 1'b1, 1'b0);
    for (int r = 1; r <= 7; r++) begin
      checks++;
      if (ov_5 !== (r == 1) || ov_1 !== (r == 5)) begin
        errors++; $display("[TB] FAIL regevery_valid r=%0d got re5=%b re1=%b exp re5=%b re1=%b", r, ov_5, ov_1, (r == 1), (r == 5));
      end
      if (r == 1) begin
        checks++;
        if (od_5 !== 8'hFF || os_5 !== 5'd31) begin
          errors++; $display("[TB] FAIL re5_data got=%h/%0d exp=ff/31", od_5, os_5);
        end
      end
      if (r == 5) begin
        checks++;
        if (od_1 !== 8'hFF || os_1 !== 5'd31) begin
          errors++; $display("[TB] FAIL re1_data got=%h/%0d exp=ff/31", od_1, os_1);
        end
      end
      idle(1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      rand_main();
      step(1'b1, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    end
    idle(4);
  endtask

  task automatic test_flush();
    idle(6);
    for (int i = 0; i < 3; i++) begin
      rand_main();
      step(1'b1, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    end
    step(1'b1, 5'd9, 1'b1, 1'b1);
    idle(5);
    rand_main();
    step(1'b1, 5'd17, 1'b1, 1'b0);
    idle(5);
  endtask

`ifdef PIPE_MUX_STALL_EN
  task automatic test_stall();
    int idx, d0;
    logic saw_low;
    idle(6);
    rand_main();
    idx = 0; d0 = delivered; saw_low = 1'b0;
    for (int r = 0; r < 30; r++) begin
      step(idx < 8, 5'(idx), !(r >= 4 && r <= 6), 1'b0);
      if (!last_rdy) saw_low = 1'b1;
      if (last_acc) idx++;
    end
    checks++;
    if (delivered - d0 != 8 || idx != 8) begin
      errors++; $display("[TB] FAIL stall_delivered got=%0d accepted=%0d exp=8", delivered - d0, idx);
    end
    checks++;
    if (!saw_low) begin
      errors++; $display("[TB] FAIL stall_in_ready_low got=never exp=at least once");
    end
  endtask
`endif

  task automatic test_random();
    logic ordy;
    for (int i = 0; i < 300; i++) begin
      rand_main();
`ifdef PIPE_MUX_STALL_EN
      ordy = ($urandom_range(0, 3) != 0);
`else
      ordy = 1'b1;
`endif
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ordy, $urandom_range(0, 19) == 0);
    end
    idle(8);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      rand_main();
      step(1'b1, 5'($urandom_range(1, 31)), 1'b1, 1'b0);
    end
    #2;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (ov_m !== 1'b0 || od_m !== '0 || os_m !== '0 || rdy_m !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs got v=%b d=%h s=%0d r=%b exp all 0", ov_m, od_m, os_m, rdy_m);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (rdy_m !== 1'b1 || ov_m !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_release got r=%b v=%b exp r=1 v=0", rdy_m, ov_m);
    end
    idle(6);
  endtask

  initial begin
    test_reset();
    test_single();
    test_width1();
    test_reg_every();
    test_back_to_back();
    test_flush();
`ifdef PIPE_MUX_STALL_EN
    test_stall();
`endif
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
